// File: rtl/fake_s2mm_pkg.sv
// Shared constants for the fake S2MM mover: command/status field layout, engine states, LFSR taps.
// Status width follows FAKE_S2MM_IBTT_EN (8 bits by default, 32 when defined).
package fake_s2mm_pkg;

  // Command fields; TAG sits CMD_TAG_OFS bits above the address LSB-aligned field width.
  localparam int CMD_BTT_LSB = 0;
  localparam int CMD_TAG_OFS = 32;
  localparam int CMD_TAG_W   = 4;

  localparam int STS_TAG_LSB   = 0;
  localparam int STS_INTERR    = 4;
  localparam int STS_DECERR    = 5;
  localparam int STS_SLVERR    = 6;
  localparam int STS_OKAY      = 7;
  localparam int STS_BYTES_LSB = 8;
  localparam int STS_BYTES_W   = 23;
  localparam int STS_EOP       = 31;

`ifdef FAKE_S2MM_IBTT_EN
  localparam int STS_W = 32;
`else
  localparam int STS_W = 8;
`endif

  // x^16+x^14+x^13+x^11 as a right-shifting Fibonacci LFSR: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_STS} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/fake_s2mm_cmd_fifo.sv
// Show-ahead synchronous command FIFO; rd_data is the head entry whenever not empty.
module fake_s2mm_cmd_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign full    = (count == DEPTH_V);
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fake_s2mm_mover.sv
// Simulation stand-in for a DataMover S2MM channel: queued commands, per-command beat
// consumption, one status beat each. FAKE_S2MM_IBTT_EN adds byte count/EOP to status.
module fake_s2mm_mover
  import fake_s2mm_pkg::*;
#(
  parameter int          MM_ADDR_WIDTH = 32,
  parameter int          BIT_WIDTH     = 128,
  parameter int          BTT_WIDTH     = 23,
  parameter int          CMD_DEPTH     = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_tvalid,
  output logic                       cmd_tready,
  input  logic [MM_ADDR_WIDTH+39:0]  cmd_tdata,
  input  logic                       throttle_en,
  input  logic [BIT_WIDTH-1:0]       s_axis_tdata,
  input  logic [BIT_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic                       sts_tvalid,
  input  logic                       sts_tready,
  output logic [STS_W-1:0]           sts_tdata,
  output logic [STS_W/8-1:0]         sts_tkeep,
  output logic                       sts_tlast,
  output logic                       sts_err,
  output logic                       busy
);
  localparam int BPB = BIT_WIDTH / 8;
  localparam int QW  = BTT_WIDTH + CMD_TAG_W;
  localparam logic [BTT_WIDTH:0] BPB_V = (BTT_WIDTH+1)'(BPB);

  logic                        q_full, q_empty, q_push, q_pop;
  logic [$clog2(CMD_DEPTH):0]  q_count;
  logic [QW-1:0]               q_rdata;
  logic [BTT_WIDTH-1:0]        pop_btt;
  logic [CMD_TAG_W-1:0]        pop_tag;
  logic [BTT_WIDTH:0]          pop_beats;

  state_t                      state, state_nxt;
  logic [BTT_WIDTH-1:0]        beat_cnt, last_idx;
  logic [CMD_TAG_W-1:0]        tag;
  logic                        okay, interr, s_hs, last_beat;
  logic [15:0]                 lfsr;
  logic [STS_W-1:0]            sts_word;

  // Reset holds cmd_tready low so every output reads 0 while rst is asserted.
  assign cmd_tready = !q_full && !rst;
  assign q_push     = cmd_tvalid && cmd_tready;

  fake_s2mm_cmd_fifo #(.W(QW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (q_push),
    .wr_data ({cmd_tdata[MM_ADDR_WIDTH+CMD_TAG_OFS +: CMD_TAG_W],
               cmd_tdata[CMD_BTT_LSB +: BTT_WIDTH]}),
    .rd_en   (q_pop),
    .rd_data (q_rdata),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign pop_btt   = q_rdata[BTT_WIDTH-1:0];
  assign pop_tag   = q_rdata[BTT_WIDTH +: CMD_TAG_W];
  assign pop_beats = ({1'b0, pop_btt} + BPB_V - 1'b1) / BPB_V;

  assign s_axis_tready = (state == ST_DATA) && !(throttle_en && lfsr[0]);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign last_beat     = (beat_cnt == last_idx);

  assign sts_tvalid = (state == ST_STS);
  assign sts_tlast  = sts_tvalid;
  assign sts_tkeep  = {(STS_W/8){sts_tvalid}};
  assign sts_err    = sts_tvalid && sts_tready && !okay;
  assign busy       = !q_empty || (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    case (state)
      ST_IDLE: if (!q_empty) begin
        q_pop     = 1'b1;
        state_nxt = (pop_btt == '0) ? ST_STS : ST_DATA;
      end
      ST_DATA: if (s_hs && (last_beat || s_axis_tlast)) state_nxt = ST_STS;
      ST_STS:  if (sts_tready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      beat_cnt <= '0;
      last_idx <= '0;
      tag      <= '0;
      okay     <= 1'b0;
      interr   <= 1'b0;
    end else begin
      if (state == ST_DATA) lfsr <= lfsr_step(lfsr);
      if (q_pop) begin
        tag      <= pop_tag;
        last_idx <= pop_beats[BTT_WIDTH-1:0] - 1'b1;
        beat_cnt <= '0;
        okay     <= 1'b0;
        interr   <= (pop_btt == '0);
      end else if (s_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (last_beat) okay <= 1'b1;
`ifdef FAKE_S2MM_IBTT_EN
        else if (s_axis_tlast) okay <= 1'b1;
`else
        else if (s_axis_tlast) interr <= 1'b1;
`endif
      end
    end
  end

`ifdef FAKE_S2MM_IBTT_EN
  logic                   eop;
  logic [STS_BYTES_W-1:0] bytes_rcv;
  logic [STS_BYTES_W:0]   bytes_sum;

  assign bytes_sum = {1'b0, bytes_rcv} + (STS_BYTES_W+1)'($countones(s_axis_tkeep));

  always_ff @(posedge clk) begin
    if (rst || q_pop) begin
      eop       <= 1'b0;
      bytes_rcv <= '0;
    end else if (s_hs) begin
      bytes_rcv <= bytes_sum[STS_BYTES_W] ? '1 : bytes_sum[STS_BYTES_W-1:0];
      // Whichever beat ends the command, EOP records whether it carried tlast.
      if (last_beat || s_axis_tlast) eop <= s_axis_tlast;
    end
  end

  logic unused;
  assign unused = ^{cmd_tdata, s_axis_tdata, pop_beats, q_count};
`else
  logic unused;
  assign unused = ^{cmd_tdata, s_axis_tdata, s_axis_tkeep, pop_beats, q_count};
`endif

  always_comb begin
    sts_word                            = '0;
    sts_word[STS_OKAY]                  = okay;
    sts_word[STS_SLVERR]                = 1'b0;
    sts_word[STS_DECERR]                = 1'b0;
    sts_word[STS_INTERR]                = interr;
    sts_word[STS_TAG_LSB +: CMD_TAG_W]  = tag;
`ifdef FAKE_S2MM_IBTT_EN
    sts_word[STS_BYTES_LSB +: STS_BYTES_W] = bytes_rcv;
    sts_word[STS_EOP]                      = eop;
`endif
  end

  assign sts_tdata = sts_tvalid ? sts_word : '0;

endmodule
